// File: rtl/joojump_button_pio.sv
// Debounced, interrupt-capable input PIO for push-buttons and switches.
// Avalon-MM slave: DATA, RAW, IRQMASK, EDGECAP (write 1 to clear).
module joojump_button_pio #(
  parameter int               WIDTH           = 3,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_MODE       = 1,
  parameter logic [WIDTH-1:0] IDLE_LEVEL      = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d_reg;
  logic [WIDTH-1:0] irqmask_reg;
  logic [WIDTH-1:0] edgecap_reg;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clr_mask;
  logic [31:0]      rd_mux;
  logic             wr;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;
  assign wr           = chipselect && !write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= IDLE_LEVEL;
      sync2_reg <= IDLE_LEVEL;
    end else begin
      sync1_reg <= in_port;
      sync2_reg <= sync1_reg;
    end
  end

  // Each bit debounces independently; a bounce back to the stable level restarts its count.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_deb
    logic [CW-1:0] cnt_reg;
    logic          stable_bit_reg;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_reg        <= '0;
        stable_bit_reg <= IDLE_LEVEL[gi];
      end else if (sync2_reg[gi] == stable_bit_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        stable_bit_reg <= sync2_reg[gi];
        cnt_reg        <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end

    assign stable[gi] = stable_bit_reg;
  end

  always_comb begin
    edge_hit = stable ^ stable_d_reg;
    case (EDGE_MODE)
      0:       edge_hit = stable & ~stable_d_reg;
      1:       edge_hit = ~stable & stable_d_reg;
      default: edge_hit = stable ^ stable_d_reg;
    endcase
  end

  assign clr_mask = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // A newly detected edge overrides a simultaneous clear of the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d_reg <= IDLE_LEVEL;
      irqmask_reg  <= '0;
      edgecap_reg  <= '0;
    end else begin
      stable_d_reg <= stable;
      edgecap_reg  <= (edgecap_reg & ~clr_mask) | edge_hit;
      if (wr && address == 2'd2) begin
        irqmask_reg <= writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = stable;
      2'd1:    rd_mux[WIDTH-1:0] = sync2_reg;
      2'd2:    rd_mux[WIDTH-1:0] = irqmask_reg;
      default: rd_mux[WIDTH-1:0] = edgecap_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  assign irq = |(edgecap_reg & irqmask_reg);

endmodule

// File: tb/tb_joojump_button_pio.sv
// Bench for joojump_button_pio: a 3-bit falling-edge instance (debounce 4) and two
// 32-bit instances (rising / any edge, debounce 1) sharing one bus.
module tb_joojump_button_pio;

  logic        clk;
  logic        reset_n;
  logic [1:0]  a_addr, b_addr;
  logic        a_cs, a_wn, b_cs, b_wn;
  logic [31:0] a_wd, b_wd;
  logic [31:0] a_rd, r_rd, y_rd;
  logic [2:0]  a_in;
  logic [31:0] b_in;
  logic        a_irq, r_irq, y_irq;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data;
    string       name;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
    int          src;
  } sb_t;

  vec_t vecs [0:16];
  sb_t  sb_q [$];

  joojump_button_pio #(.WIDTH(3), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(a_addr), .chipselect(a_cs), .write_n(a_wn),
    .writedata(a_wd), .readdata(a_rd), .in_port(a_in), .irq(a_irq)
  );

  joojump_button_pio #(.WIDTH(32), .DEBOUNCE_CYCLES(1), .EDGE_MODE(0)) dut_r (
    .clk(clk), .reset_n(reset_n), .address(b_addr), .chipselect(b_cs), .write_n(b_wn),
    .writedata(b_wd), .readdata(r_rd), .in_port(b_in), .irq(r_irq)
  );

  joojump_button_pio #(.WIDTH(32), .DEBOUNCE_CYCLES(1), .EDGE_MODE(2)) dut_y (
    .clk(clk), .reset_n(reset_n), .address(b_addr), .chipselect(b_cs), .write_n(b_wn),
    .writedata(b_wd), .readdata(y_rd), .in_port(b_in), .irq(y_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic push_exp(input string name, input logic [31:0] exp, input int src);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    e.src  = src;
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    sb_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      case (e.src)
        0:       check(e.name, a_rd, e.exp);
        1:       check(e.name, r_rd, e.exp);
        default: check(e.name, y_rd, e.exp);
      endcase
    end
  endtask

  task automatic wr_a(input logic [1:0] addr, input logic [31:0] data);
    a_addr = addr; a_wd = data; a_cs = 1'b1; a_wn = 1'b0;
    @(negedge clk);
    a_cs = 1'b0; a_wn = 1'b1;
  endtask

  task automatic rd_a(input logic [1:0] addr, input logic [31:0] exp, input string name);
    a_addr = addr;
    push_exp(name, exp, 0);
    @(negedge clk);
    pop_check();
  endtask

  task automatic wr_b(input logic [1:0] addr, input logic [31:0] data);
    b_addr = addr; b_wd = data; b_cs = 1'b1; b_wn = 1'b0;
    @(negedge clk);
    b_cs = 1'b0; b_wn = 1'b1;
  endtask

  task automatic rd_b(input logic [1:0] addr, input logic [31:0] exp_r,
                      input logic [31:0] exp_y, input string name);
    b_addr = addr;
    push_exp({name, "_rise"}, exp_r, 1);
    push_exp({name, "_any"}, exp_y, 2);
    @(negedge clk);
    pop_check();
    pop_check();
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].we) wr_a(vecs[i].addr, vecs[i].data);
      else            rd_a(vecs[i].addr, vecs[i].data, vecs[i].name);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 2'd0, 32'h7,        "data_idle"};
    vecs[1]  = '{1'b0, 2'd1, 32'h7,        "raw_idle"};
    vecs[2]  = '{1'b0, 2'd2, 32'h0,        "mask_rst"};
    vecs[3]  = '{1'b0, 2'd3, 32'h0,        "ecap_rst"};
    vecs[4]  = '{1'b1, 2'd2, 32'h5,        "wr_mask5"};
    vecs[5]  = '{1'b0, 2'd2, 32'h5,        "mask_rw"};
    vecs[6]  = '{1'b1, 2'd2, 32'hFFFF_FFF2, "wr_mask_wide"};
    vecs[7]  = '{1'b0, 2'd2, 32'h2,        "mask_zext"};
    vecs[8]  = '{1'b1, 2'd0, 32'h0,        "wr_data"};
    vecs[9]  = '{1'b1, 2'd1, 32'h0,        "wr_raw"};
    vecs[10] = '{1'b0, 2'd0, 32'h7,        "data_ro"};
    vecs[11] = '{1'b0, 2'd1, 32'h7,        "raw_ro"};
    vecs[12] = '{1'b1, 2'd2, 32'h1,        "wr_mask1"};
    vecs[13] = '{1'b0, 2'd0, 32'h7,        "rst_data"};
    vecs[14] = '{1'b0, 2'd1, 32'h7,        "rst_raw"};
    vecs[15] = '{1'b0, 2'd2, 32'h0,        "rst_mask"};
    vecs[16] = '{1'b0, 2'd3, 32'h0,        "rst_ecap"};

    reset_n = 1'b0;
    a_addr = 2'd0; a_cs = 1'b0; a_wn = 1'b1; a_wd = '0; a_in = 3'b111;
    b_addr = 2'd0; b_cs = 1'b0; b_wn = 1'b1; b_wd = '0; b_in = '1;
    repeat (3) @(negedge clk);
    check("rd_reset", a_rd, 32'h0);
    check("irq_reset", 32'(a_irq), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    run_vecs(0, 12);

    // 3-cycle glitch on bit0: RAW follows two edges late, DATA never moves
    a_addr = 2'd1;
    a_in   = 3'b110;
    for (int i = 1; i <= 8; i++) begin
      push_exp("raw_glitch", (i >= 3 && i <= 5) ? 32'h6 : 32'h7, 0);
      @(negedge clk);
      pop_check();
      if (i == 3) a_in = 3'b111;
    end
    repeat (4) @(negedge clk);
    rd_a(2'd0, 32'h7, "data_glitch");
    rd_a(2'd3, 32'h0, "ecap_glitch");
    check("irq_glitch", 32'(a_irq), 32'h0);

    // held fall on bit0: stable at edge k+5, readdata one edge later, irq at k+6
    a_addr = 2'd0;
    a_in   = 3'b110;
    for (int i = 1; i <= 9; i++) begin
      push_exp("data_fall", (i >= 7) ? 32'h6 : 32'h7, 0);
      @(negedge clk);
      pop_check();
      check("irq_fall", 32'(a_irq), (i >= 7) ? 32'h1 : 32'h0);
    end

    a_in = 3'b010;
    repeat (10) @(negedge clk);
    rd_a(2'd3, 32'h5, "ecap_101");
    check("irq_101", 32'(a_irq), 32'h1);
    wr_a(2'd3, 32'h1);
    check("irq_clr", 32'(a_irq), 32'h0);
    rd_a(2'd3, 32'h4, "ecap_100");

    // clear of bit1 lands on the very edge its falling edge is captured
    a_in = 3'b000;
    repeat (6) @(negedge clk);
    wr_a(2'd3, 32'h2);
    rd_a(2'd3, 32'h6, "ecap_setwin");
    wr_a(2'd3, 32'h2);
    rd_a(2'd3, 32'h4, "ecap_clr1");

    // asynchronous reset in mid-cycle
    wr_a(2'd2, 32'h7);
    check("irq_pre_rst", 32'(a_irq), 32'h1);
    a_addr = 2'd2;
    a_in   = 3'b010;
    @(negedge clk);
    check("rd_pre_rst", a_rd, 32'h7);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rd_in_rst", a_rd, 32'h0);
    check("irq_in_rst", 32'(a_irq), 32'h0);
    repeat (3) @(negedge clk);
    a_in    = 3'b111;
    reset_n = 1'b1;
    @(negedge clk);
    run_vecs(13, 16);

    // 32-bit instances: bit31 toggles 0->1->0
    b_in[31] = 1'b0;
    repeat (6) @(negedge clk);
    wr_b(2'd3, 32'hFFFF_FFFF);
    wr_b(2'd2, 32'h8000_0000);
    rd_b(2'd3, 32'h0, 32'h0, "b_ecap_clr");
    rd_b(2'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, "b_data");
    rd_b(2'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, "b_raw");

    b_in[31] = 1'b1;
    repeat (6) @(negedge clk);
    rd_b(2'd3, 32'h8000_0000, 32'h8000_0000, "b_ecap_up");
    check("r_irq_up", 32'(r_irq), 32'h1);
    check("y_irq_up", 32'(y_irq), 32'h1);
    wr_b(2'd3, 32'h8000_0000);
    rd_b(2'd3, 32'h0, 32'h0, "b_ecap_cleared");

    b_in[31] = 1'b0;
    repeat (6) @(negedge clk);
    rd_b(2'd3, 32'h0, 32'h8000_0000, "b_ecap_down");
    check("r_irq_down", 32'(r_irq), 32'h0);
    check("y_irq_down", 32'(y_irq), 32'h1);

    // back-to-back reads of alternating addresses: one-cycle latency
    rd_b(2'd2, 32'h8000_0000, 32'h8000_0000, "b_lat_mask");
    rd_b(2'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, "b_lat_data");
    rd_b(2'd2, 32'h8000_0000, 32'h8000_0000, "b_lat_mask2");
    rd_b(2'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, "b_lat_raw");

    // single-cycle debounce: stable moves at edge k+2, readdata at k+3
    b_addr  = 2'd0;
    b_in[0] = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      push_exp("b_deb1_rise", (i >= 4) ? 32'h7FFF_FFFE : 32'h7FFF_FFFF, 1);
      push_exp("b_deb1_any", (i >= 4) ? 32'h7FFF_FFFE : 32'h7FFF_FFFF, 2);
      @(negedge clk);
      pop_check();
      pop_check();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
